disp_scheduler: RTL
===================

DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot.
REQ-002 SHALL have parameter BLINK_FRAMES, default 64: full 8-digit frames per blink half-period.
REQ-003 SHALL have parameter ALARM_FRAMES, default 1024: frames before an unacknowledged alarm times out.
REQ-004 SHALL have port clk  in  1: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-006 SHALL have port time_bcd  in  32: running time, 8 BCD digits, digit k at [4k+3:4k].
REQ-007 SHALL have port set_bcd  in  32: time-setting string, same packing.
REQ-008 SHALL have port set_active  in  1: level request for the set view.
REQ-009 SHALL have port set_cursor  in  3: index of the digit under edit.
REQ-010 SHALL have port alarm_bcd  in  32: alarm message, same packing.
REQ-011 SHALL have port alarm_req  in  1: one-cycle pulse that raises an alarm.
REQ-012 SHALL have port ack_alarm  in  1: one-cycle pulse that clears the alarm (mid button).
REQ-013 SHALL have port chs  out  8: digit select, active-low one-hot.
REQ-014 SHALL have port digit  out  4: BCD code to the segment decoder; 4'hF means blank.
REQ-015 SHALL have port src  out  2: source now displayed; 0=time, 1=set, 2=alarm.
REQ-016 SHALL have port frame_tick  out  1: one-cycle pulse at each frame wrap.

Function
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and assert scan_tick while at SCAN_DIV-1.
REQ-018 Digit index idx (3 bits) SHALL increment modulo 8 on scan_tick; 7->0 is a frame wrap.
REQ-019 On the edge after scan_tick, chs SHALL equal ~(1<<idx_new) and digit SHALL be the selected source nibble for idx_new; chs and digit change on the same edge.
REQ-020 frame_tick SHALL be high for exactly the one cycle after the edge on which idx wraps 7->0.
REQ-021 States SHALL be S_TIME, S_SET and S_ALARM, with priority alarm_pend > set_active > time.
REQ-022 State changes SHALL occur only at a frame wrap, so no frame mixes sources; src SHALL update on that same edge.
REQ-023 alarm_pend SHALL set on alarm_req and clear on ack_alarm or on timeout; if both pulses coincide, alarm_req wins.
REQ-024 The alarm timeout counter SHALL count frames while in S_ALARM and clear alarm_pend when it reaches ALARM_FRAMES; it resets on alarm_req and on entry to S_ALARM.
REQ-025 blink_on SHALL toggle every BLINK_FRAMES frames, and SHALL be forced to 1 with its counter cleared on any state change.
REQ-026 In S_SET, digit SHALL be 4'hF when idx==set_cursor and blink_on==0; otherwise digit SHALL be the set_bcd nibble.
REQ-027 In S_ALARM, digit SHALL be 4'hF for all slots while blink_on==0.
REQ-028 BCD nibbles SHALL pass through unmodified, including values above 9; blanking applies only under REQ-026 and REQ-027.
REQ-029 Changes to set_cursor or the bcd inputs SHALL take effect at the next scan_tick, never mid-slot.

Reset
REQ-030 While rst is high: prescaler=0, idx=0, chs=8'hFE, digit=4'hF, src=0, state=S_TIME, blink_on=1, blink and timeout counters=0, alarm_pend=0, frame_tick=0.
REQ-031 rst SHALL override all inputs; asserting it mid-frame or mid-alarm SHALL drop a pending alarm, and the first post-reset frame SHALL show time.

Verification (SCAN_DIV=4, BLINK_FRAMES=2, ALARM_FRAMES=4)
REQ-032 Reset, time_bcd=32'h12345678 -> chs cycles FE,FD,FB,...,7F, each for 4 clk; digit 8,7,6,5,4,3,2,1; frame_tick pulses every 32 clk.
REQ-033 set_active raised mid-frame, set_cursor=3 -> src goes to 1 only at the next wrap; digit 3 blank in frames 3-4, visible in frames 1-2 and 5-6.
REQ-034 alarm_req while set_active=1 -> S_ALARM at the next wrap with src=2; whole display blanked in alternate 2-frame periods; after 4 frames alarm_pend clears and src returns to 1.
REQ-035 ack_alarm and alarm_req in the same cycle -> alarm stays pending and the timeout counter restarts.
REQ-036 rst pulsed during S_ALARM slot 5 -> next clk chs=FE, digit=F, src=0; alarm does not reappear.

Source files
------------

// File: rtl/disp_scheduler.sv
// Time-multiplexed 8-digit display scheduler: scans digits, picks the time / set / alarm
// source once per frame, and blinks the edited digit or the whole alarm message.
module disp_scheduler #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter int ALARM_FRAMES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] time_bcd,
   input  logic [31:0] set_bcd,
   input  logic        set_active,
   input  logic [2:0]  set_cursor,
   input  logic [31:0] alarm_bcd,
   input  logic        alarm_req,
   input  logic        ack_alarm,
   output logic [7:0]  chs,
   output logic [3:0]  digit,
   output logic [1:0]  src,
   output logic        frame_tick
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int AW = (ALARM_FRAMES > 1) ? $clog2(ALARM_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
   localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_FRAMES - 1);

   typedef enum logic [1:0] {
      S_TIME  = 2'd0,
      S_SET   = 2'd1,
      S_ALARM = 2'd2
   } state_t;

   logic [PW-1:0] r_presc;
   logic [2:0]    r_idx;
   logic [7:0]    r_chs;
   logic [3:0]    r_digit;
   logic          r_frame_tick;
   state_t        r_state;
   logic          r_blink_on;
   logic [BW-1:0] r_blink_cnt;
   logic [AW-1:0] r_to_cnt;
   logic          r_alarm_pend;

   logic          w_scan_tick;
   logic          w_wrap;
   logic [2:0]    w_idx_next;
   logic          w_timeout;
   logic          w_pend_next;
   state_t        w_state_next;
   logic          w_state_chg;
   logic          w_blink_next;
   logic [BW-1:0] w_blink_cnt_next;
   logic [AW-1:0] w_to_cnt_next;
   logic [3:0]    w_nib;
   logic [3:0]    w_digit_next;

   // NOTE: every always_comb output gets a default first so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      w_scan_tick = (r_presc == PRESC_MAX);
      w_wrap      = w_scan_tick && (r_idx == 3'd7);
      w_idx_next  = r_idx + 3'd1;
      w_timeout   = w_wrap && (r_state == S_ALARM) && (r_to_cnt == ALARM_MAX);

      w_pend_next = r_alarm_pend;
      if (alarm_req)
         w_pend_next = 1'b1;
      else if (ack_alarm || w_timeout)
         w_pend_next = 1'b0;

      // The next pending value is used so a timeout leaves S_ALARM on the same wrap.
      w_state_next = r_state;
      if (w_wrap) begin
         if (w_pend_next)     w_state_next = S_ALARM;
         else if (set_active) w_state_next = S_SET;
         else                 w_state_next = S_TIME;
      end
      w_state_chg = (w_state_next != r_state);

      w_blink_next     = r_blink_on;
      w_blink_cnt_next = r_blink_cnt;
      if (w_state_chg) begin
         w_blink_next     = 1'b1;
         w_blink_cnt_next = '0;
      end else if (w_wrap) begin
         if (r_blink_cnt == BLINK_MAX) begin
            w_blink_next     = ~r_blink_on;
            w_blink_cnt_next = '0;
         end else begin
            w_blink_cnt_next = r_blink_cnt + 1'b1;
         end
      end

      w_to_cnt_next = r_to_cnt;
      if (alarm_req)
         w_to_cnt_next = '0;
      else if (w_state_chg && (w_state_next == S_ALARM))
         w_to_cnt_next = '0;
      else if (w_wrap && (r_state == S_ALARM))
         w_to_cnt_next = w_timeout ? '0 : r_to_cnt + 1'b1;

      // The slot about to be shown uses the state and blink phase of its own frame.
      case (w_state_next)
         S_SET:   w_nib = set_bcd[{w_idx_next, 2'b00} +: 4];
         S_ALARM: w_nib = alarm_bcd[{w_idx_next, 2'b00} +: 4];
         default: w_nib = time_bcd[{w_idx_next, 2'b00} +: 4];
      endcase
      w_digit_next = w_nib;
      if ((w_state_next == S_SET) && (w_idx_next == set_cursor) && !w_blink_next)
         w_digit_next = 4'hF;
      if ((w_state_next == S_ALARM) && !w_blink_next)
         w_digit_next = 4'hF;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc      <= '0;
         r_idx        <= 3'd0;
         r_chs        <= 8'hFE;
         r_digit      <= 4'hF;
         r_frame_tick <= 1'b0;
         r_state      <= S_TIME;
         r_blink_on   <= 1'b1;
         r_blink_cnt  <= '0;
         r_to_cnt     <= '0;
         r_alarm_pend <= 1'b0;
      end else begin
         r_presc      <= w_scan_tick ? '0 : r_presc + 1'b1;
         r_frame_tick <= w_wrap;
         r_state      <= w_state_next;
         r_blink_on   <= w_blink_next;
         r_blink_cnt  <= w_blink_cnt_next;
         r_to_cnt     <= w_to_cnt_next;
         r_alarm_pend <= w_pend_next;
         if (w_scan_tick) begin
            r_idx   <= w_idx_next;
            r_chs   <= ~(8'd1 << w_idx_next);
            r_digit <= w_digit_next;
         end
      end
   end

   assign chs        = r_chs;
   assign digit      = r_digit;
   assign src        = r_state;
   assign frame_tick = r_frame_tick;

endmodule
